guess_game_ctrl: RTL

- Consumes the 7-bit pseudo-random word from the upstream LFSR stage.
- On `start`, latches that word as a secret target folded into 0..MAX_VAL.
- Compares each player guess against the target and reports too high, too low or correct.
- Counts attempts and ends the round in WIN or LOSE; its outputs feed the display/LED stage.

---
 rtl/guess_pkg.sv | 17 +
 rtl/guess_timer.sv | 25 ++
 rtl/guess_game_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/guess_pkg.sv
// Shared types and defaults for the number-guessing round controller.
package guess_pkg;

    typedef enum logic [2:0] {IDLE, ARM, PLAY, WIN, LOSE} state_e;
    typedef enum logic [1:0] {RES_NONE, RES_LOW, RES_HIGH, RES_OK} result_e;

    localparam int DEF_MAX_VAL      = 99;
    localparam int DEF_MAX_ATTEMPTS = 7;

    // Fold a raw 7-bit random word into 0..maxv with a single subtraction.
    function automatic logic [6:0] fold(input logic [6:0] r, input int maxv);
        logic [7:0] lim;
        lim = 8'(maxv + 1);
        return ({1'b0, r} >= lim) ? 7'({1'b0, r} - lim) : r;
    endfunction

endpackage

// File: rtl/guess_timer.sv
// Idle-timeout down-counter: reloads on load, counts down while enabled.
module guess_timer #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int            W      = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0]  RELOAD = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  cnt <= '0;
        else if (load)                 cnt <= RELOAD;
        else if (enable && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/guess_game_ctrl.sv
// Guess-the-number round controller. Optional idle timeout: define GUESS_TIMEOUT_EN.
module guess_game_ctrl
    import guess_pkg::*;
#(
    parameter int MAX_VAL        = DEF_MAX_VAL,
    parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] rnd,
    input  logic       start,
    input  logic [6:0] guess,
    input  logic       guess_valid,
    output logic       busy,
    output logic       too_high,
    output logic       too_low,
    output logic       correct,
    output logic       guess_err,
    output logic [3:0] attempts,
    output logic       win,
    output logic       lose,
    output logic       timeout
);

    state_e     state, nxt;
    result_e    res;
    logic [6:0] target;
    logic [3:0] att_q;
    logic       err_q, tmo_q, expired;

    // start beats a same-cycle guess, so a guess only counts without start
    logic in_play, acc, legal, good, hit, last;
    assign in_play = (state == PLAY);
    assign acc     = in_play && guess_valid && !start;
    assign legal   = (guess <= 7'(MAX_VAL));
    assign good    = acc && legal;
    assign hit     = (guess == target);
    assign last    = ((att_q + 4'd1) == 4'(MAX_ATTEMPTS));

`ifdef GUESS_TIMEOUT_EN
    guess_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    ((state == ARM) || good),
        .enable  (in_play),
        .expired (expired)
    );
`else
    // No timer built: never expires.
    assign expired = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (start) nxt = ARM;
            ARM:      nxt = PLAY;
            PLAY: begin
                if (start)                   nxt = ARM;
                else if (good && hit)        nxt = WIN;
                else if (good && last)       nxt = LOSE;
                else if (!good && expired)   nxt = LOSE;
            end
            WIN, LOSE: if (start) nxt = ARM;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target <= '0;
            att_q  <= '0;
            res    <= RES_NONE;
            err_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            err_q <= acc && !legal;
            if (in_play && !start && !good && expired) tmo_q <= 1'b1;
            if (state != ARM && nxt == ARM) begin
                att_q <= '0;
                tmo_q <= 1'b0;
            end else if (state == ARM) begin
                target <= fold(rnd, MAX_VAL);
                att_q  <= '0;
                res    <= RES_NONE;
            end else if (good) begin
                att_q <= att_q + 4'd1;
                res   <= hit ? RES_OK : ((guess > target) ? RES_HIGH : RES_LOW);
            end
        end
    end

    always_comb begin
        busy      = (state == ARM) || (state == PLAY);
        win       = (state == WIN);
        lose      = (state == LOSE);
        timeout   = tmo_q && (state == LOSE);
        too_high  = (res == RES_HIGH);
        too_low   = (res == RES_LOW);
        correct   = (res == RES_OK);
        guess_err = err_q;
        attempts  = att_q;
    end

endmodule
